seg7_scan_sched: RTL

//  Time-multiplexes one shared BCD7 decoder and one 7-seg segment bus across N_DIGITS

---
 rtl/seg7_scan_sched_if.sv | 23 ++
 rtl/seg7_scan_sched.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_sched_if.sv
// Signal bundle between the digit datapath/board side and the 7-segment scan scheduler.
// The master drives digit values, enable and decoded segments; the slave is the scheduler.
interface seg7_scan_sched_if #(
  parameter int N_DIGITS = 4
);
  logic                    en;
  logic [4*N_DIGITS-1:0]   digits;
  logic [6:0]              seg_raw;
  logic [3:0]              bcd_sel;
  logic [6:0]              shuchu;
  logic [N_DIGITS-1:0]     an_n;
  logic                    frame_done;

  modport master (
    output en, digits, seg_raw,
    input  bcd_sel, shuchu, an_n, frame_done
  );

  modport slave (
    input  en, digits, seg_raw,
    output bcd_sel, shuchu, an_n, frame_done
  );
endinterface

// File: rtl/seg7_scan_sched.sv
// Multiplexes one shared BCD7 decoder and segment bus across N_DIGITS common-anode digits.
// Optional leading-zero suppression is enabled by defining LZ_SUPPRESS_EN.
module seg7_scan_sched #(
  parameter int N_DIGITS    = 4,
  parameter int TICK_DIV    = 1000,
  parameter int SHOW_TICKS  = 4,
  parameter int BLANK_TICKS = 1
) (
  input  logic             clk,
  input  logic             reset,
  seg7_scan_sched_if.slave bus
);
  localparam int IW   = $clog2(N_DIGITS);
  localparam int PW   = $clog2(TICK_DIV + 1);
  localparam int TMAX = (SHOW_TICKS > BLANK_TICKS) ? SHOW_TICKS : BLANK_TICKS;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [TW-1:0] SHOW_LAST  = TW'(SHOW_TICKS - 1);
  localparam logic [TW-1:0] BLANK_LAST = TW'((BLANK_TICKS > 0) ? BLANK_TICKS - 1 : 0);
  localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIGITS - 1);

  typedef enum logic [1:0] {S_IDLE, S_BLANK, S_SHOW} state_t;

  state_t                  state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d, idx_nx;
  logic [PW-1:0]           presc_q, presc_d;
  logic [TW-1:0]           tcnt_q, tcnt_d;
  logic [4*N_DIGITS-1:0]   snap_q, snap_d;
  logic [3:0]              bcd_q, bcd_d;
  logic [N_DIGITS-1:0]     an_q, an_d;
  logic                    fd_q, fd_d;
  logic                    tick;
  logic                    suppress;
  logic [3:0]              snap_dig [N_DIGITS];

  for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_dig
    assign snap_dig[gi] = snap_q[4*gi +: 4];
  end

  function automatic logic [N_DIGITS-1:0] an_sel(input logic [IW-1:0] i);
    an_sel = ~(N_DIGITS'(1) << i);
  endfunction

`ifdef LZ_SUPPRESS_EN
  // A digit is blanked while it and every more significant digit are zero.
  logic [N_DIGITS-1:0] lz;
  always_comb begin
    logic run;
    lz  = '0;
    run = 1'b1;
    for (int i = N_DIGITS - 1; i >= 1; i--) begin
      run   = run && (snap_dig[i] == 4'd0);
      lz[i] = run;
    end
  end
  assign suppress = lz[idx_q];
`else
  assign suppress = 1'b0;
`endif

  assign tick = (state_q != S_IDLE) && (presc_q == PRESC_LAST);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    idx_nx  = idx_q;
    presc_d = presc_q;
    tcnt_d  = tcnt_q;
    snap_d  = snap_q;
    bcd_d   = bcd_q;
    an_d    = an_q;
    fd_d    = 1'b0;
    if (!bus.en) begin
      state_d = S_IDLE;
      an_d    = '1;
      presc_d = '0;
      tcnt_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          snap_d  = bus.digits;
          idx_d   = '0;
          bcd_d   = bus.digits[3:0];
          presc_d = '0;
          tcnt_d  = '0;
          if (BLANK_TICKS == 0) begin
            state_d = S_SHOW;
            an_d    = an_sel('0);
          end else begin
            state_d = S_BLANK;
            an_d    = '1;
          end
        end
        S_BLANK: begin
          presc_d = tick ? '0 : presc_q + PW'(1);
          if (tick) begin
            if (tcnt_q == BLANK_LAST) begin
              state_d = S_SHOW;
              tcnt_d  = '0;
              an_d    = an_sel(idx_q);
            end else begin
              tcnt_d = tcnt_q + TW'(1);
            end
          end
        end
        S_SHOW: begin
          presc_d = tick ? '0 : presc_q + PW'(1);
          if (tick) begin
            if (tcnt_q == SHOW_LAST) begin
              tcnt_d = '0;
              // Frame wrap re-samples the inputs so the next frame is coherent.
              if (idx_q == IDX_LAST) begin
                idx_nx = '0;
                snap_d = bus.digits;
                fd_d   = 1'b1;
                bcd_d  = bus.digits[3:0];
              end else begin
                idx_nx = idx_q + IW'(1);
                bcd_d  = snap_dig[idx_nx];
              end
              idx_d = idx_nx;
              if (BLANK_TICKS == 0) begin
                state_d = S_SHOW;
                an_d    = an_sel(idx_nx);
              end else begin
                state_d = S_BLANK;
                an_d    = '1;
              end
            end else begin
              tcnt_d = tcnt_q + TW'(1);
            end
          end
        end
        default: begin
          state_d = S_IDLE;
          an_d    = '1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      presc_q <= '0;
      tcnt_q  <= '0;
      snap_q  <= '0;
      bcd_q   <= '0;
      an_q    <= '1;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      presc_q <= presc_d;
      tcnt_q  <= tcnt_d;
      snap_q  <= snap_d;
      bcd_q   <= bcd_d;
      an_q    <= an_d;
      fd_q    <= fd_d;
    end
  end

  assign bus.bcd_sel    = bcd_q;
  assign bus.an_n       = an_q;
  assign bus.frame_done = fd_q;
  assign bus.shuchu     = (state_q == S_SHOW && !suppress) ? ~bus.seg_raw : 7'h7F;
endmodule
